// File: rtl/serial_chunk_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_chunk_adder_pkg
// Purpose : Shared definitions for the serial chunk adder: FSM state
//           encoding, derived-size helper functions and a parameter check
//           macro used at elaboration.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================

// Elaboration-time legality check for the WIDTH/CHUNK pair. Expands to a
// labelled generate block that raises an elaboration error when illegal.
`define SCA_PARAM_CHECK(W, C) \
    if (((C) < 1) || ((C) > (W)) || (((W) % (C)) != 0)) begin : g_param_err \
        $error("serial_chunk_adder: illegal WIDTH/CHUNK combination"); \
    end

package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of chunk cycles needed to cover the full operand.
    function automatic int sca_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width; one spare bit so NCHUNK itself is representable.
    function automatic int sca_cnt_w(input int width, input int chunk);
        return $clog2(width / chunk) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_chunk_adder_chunk.sv
`default_nettype none
// ============================================================================
// Module  : chunk_adder
// Purpose : Combinational CHUNK-bit ripple-carry adder built from 1-bit full
//           adders.
// Ports   : x, y [CHUNK] - addends
//           ci            - carry in
//           s  [CHUNK]    - sum
//           co            - carry out of the top bit
// Revision: 1.0 - initial release
// ============================================================================
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    // Ripple the carry through a scalar so no self-referencing vector chain
    // is created.
    logic w_carry;

    always_comb begin
        w_carry = ci;
        s       = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]    = x[i] ^ y[i] ^ w_carry;
            w_carry = (x[i] & y[i]) | (w_carry & (x[i] ^ y[i]));
        end
        co = w_carry;
    end

endmodule

`default_nettype wire

// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module  : serial_chunk_adder
// Purpose : Multi-cycle add/subtract unit. WIDTH-bit operands are processed
//           CHUNK bits per clock through a single CHUNK-bit adder with the
//           carry held in a register between cycles. Valid/ready on both
//           sides; reports carry-out and signed overflow.
// Ports   : clk, rst_n            - clock, async active-low reset
//           in_valid/in_ready     - operand handshake
//           a, b [WIDTH], cin, sub- operands, carry-in, subtract select
//           out_valid/out_ready   - result handshake
//           sum [WIDTH], cout, ovf- result, carry-out, signed overflow
// Revision: 1.0 - initial release
// ============================================================================
module serial_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    import serial_chunk_adder_pkg::*;

    localparam int NCHUNK = sca_nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = sca_cnt_w(WIDTH, CHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    `SCA_PARAM_CHECK(WIDTH, CHUNK)

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic             carry_q,     carry_d;
    logic             msb_a_q,     msb_a_d;
    logic             msb_b_q,     msb_b_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             ovf_q,       ovf_d;

    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co;
    logic [WIDTH-1:0] res_next;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x  (a_sh_q[CHUNK-1:0]),
        .y  (b_sh_q[CHUNK-1:0]),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // Each chunk sum enters at the top of the result register; after NCHUNK
    // shifts the first (least significant) chunk has reached bit 0.
    if (NCHUNK == 1) begin : g_res_single
        assign res_next = chunk_s;
    end else begin : g_res_multi
        assign res_next = {chunk_s, res_q[WIDTH-1:CHUNK]};
    end

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        carry_d     = carry_q;
        msb_a_d     = msb_a_q;
        msb_b_d     = msb_b_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    // Subtraction is a + ~b + 1: invert b and force carry-in.
                    a_sh_d     = a;
                    b_sh_d     = sub ? ~b : b;
                    carry_d    = sub | cin;
                    msb_a_d    = a[WIDTH-1];
                    msb_b_d    = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end

            ST_RUN: begin
                a_sh_d  = a_sh_q >> CHUNK;
                b_sh_d  = b_sh_q >> CHUNK;
                res_d   = res_next;
                carry_d = chunk_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    sum_d       = res_next;
                    cout_d      = chunk_co;
                    ovf_d       = (msb_a_q == msb_b_q) &&
                                  (res_next[WIDTH-1] != msb_a_q);
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            msb_a_q     <= 1'b0;
            msb_b_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            msb_a_q     <= msb_a_d;
            msb_b_q     <= msb_b_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire
